// File: rtl/cva6_tlb_sv32.sv
// Four-entry fully associative Sv32 TLB: combinational lookup, single-cycle fill,
// selective/global flush and tree-PLRU replacement.
module cva6_tlb_sv32 #(
    parameter int unsigned TLB_ENTRIES = 4,
    parameter int unsigned ASID_WIDTH  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [62:0]               update_i,
    input  logic                      lu_access_i,
    input  logic [ASID_WIDTH-1:0]     lu_asid_i,
    input  logic [31:0]               lu_vaddr_i,
    output logic [31:0]               lu_content_o,
    input  logic [ASID_WIDTH-1:0]     asid_to_be_flushed_i,
    input  logic [31:0]               vaddr_to_be_flushed_i,
    output logic                      lu_is_4M_o,
    output logic                      lu_hit_o,
    output logic [TLB_ENTRIES*32-1:0] port_content_q_o,
    output logic [TLB_ENTRIES*31-1:0] port_tags_q_o
);
    localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

    logic [30:0] tags_q    [TLB_ENTRIES];
    logic [30:0] tags_d    [TLB_ENTRIES];
    logic [31:0] content_q [TLB_ENTRIES];
    logic [31:0] content_d [TLB_ENTRIES];
    logic [2:0]  plru_q, plru_d;

    logic [8:0]             lu_asid_ext, fl_asid_ext;
    logic [TLB_ENTRIES-1:0] lu_match, fl_sel;
    logic [IDX_W-1:0]       hit_idx, upd_idx;
    logic                   has_invalid;
    logic                   lu_unused;

    assign lu_unused = ^lu_vaddr_i[11:0];

    // Path bits point away from the touched leaf: b0 selects the half, b1/b2 the leaf.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [IDX_W-1:0] idx);
        logic [2:0] r;
        r    = p;
        r[0] = ~idx[1];
        if (idx[1]) r[2] = ~idx[0];
        else        r[1] = ~idx[0];
        return r;
    endfunction

    always_comb begin
        lu_asid_ext                 = '0;
        lu_asid_ext[ASID_WIDTH-1:0] = lu_asid_i;
        fl_asid_ext                 = '0;
        fl_asid_ext[ASID_WIDTH-1:0] = asid_to_be_flushed_i;
    end

    always_comb begin
        lu_match     = '0;
        hit_idx      = '0;
        lu_hit_o     = 1'b0;
        lu_content_o = '0;
        lu_is_4M_o   = 1'b0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            lu_match[i] = tags_q[i][0]
                       && (tags_q[i][21:12] == lu_vaddr_i[31:22])
                       && (tags_q[i][1] || (tags_q[i][11:2] == lu_vaddr_i[21:12]))
                       && ((tags_q[i][30:22] == lu_asid_ext) || content_q[i][5]);
            if (lu_match[i]) begin
                hit_idx      = IDX_W'(i);
                lu_hit_o     = 1'b1;
                lu_content_o = content_q[i];
                lu_is_4M_o   = tags_q[i][1];
            end
        end
    end

    always_comb begin
        fl_sel = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            logic vmatch, amatch;
            vmatch = (tags_q[i][21:12] == vaddr_to_be_flushed_i[31:22])
                  && (tags_q[i][1] || (tags_q[i][11:2] == vaddr_to_be_flushed_i[21:12]));
            amatch = (tags_q[i][30:22] == fl_asid_ext) && !content_q[i][5];
            if (fl_asid_ext == 9'd0 && vaddr_to_be_flushed_i == 32'd0) fl_sel[i] = 1'b1;
            else if (fl_asid_ext == 9'd0)                                 fl_sel[i] = vmatch;
            else if (vaddr_to_be_flushed_i == 32'd0)                      fl_sel[i] = amatch;
            else                                                          fl_sel[i] = amatch && vmatch;
        end
    end

    // Fill target: lowest invalid slot, falling back to the PLRU victim when full.
    always_comb begin
        has_invalid = 1'b0;
        upd_idx     = plru_q[0] ? {1'b1, plru_q[2]} : {1'b0, plru_q[1]};
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!tags_q[i][0]) begin
                has_invalid = 1'b1;
                upd_idx     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        tags_d    = tags_q;
        content_d = content_q;
        plru_d    = plru_q;
        if (lu_access_i && lu_hit_o) plru_d = plru_touch(plru_d, hit_idx);
        if (flush_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (fl_sel[i]) tags_d[i][0] = 1'b0;
            end
        end else if (update_i[62]) begin
            tags_d[upd_idx]    = {update_i[40:32], update_i[60:51], update_i[50:41], update_i[61], 1'b1};
            content_d[upd_idx] = update_i[31:0];
            plru_d             = plru_touch(plru_d, upd_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tags_q[i]    <= '0;
                content_q[i] <= '0;
            end
            plru_q <= '0;
        end else begin
            tags_q    <= tags_d;
            content_q <= content_d;
            plru_q    <= plru_d;
        end
    end

    always_comb begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            port_tags_q_o[i*31 +: 31]    = tags_q[i];
            port_content_q_o[i*32 +: 32] = content_q[i];
        end
    end

endmodule

// File: tb/tb_cva6_tlb_sv32.sv
// Directed scoreboard bench for cva6_tlb_sv32: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cva6_tlb_sv32;
    localparam int K_HIT = 0, K_CONT = 1, K_4M = 2, K_TAG = 3, K_ECONT = 4, K_VALID = 5;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic [62:0]  update_i;
    logic         lu_access_i;
    logic [0:0]   lu_asid_i;
    logic [31:0]  lu_vaddr_i;
    logic [31:0]  lu_content_o;
    logic [0:0]   asid_to_be_flushed_i;
    logic [31:0]  vaddr_to_be_flushed_i;
    logic         lu_is_4M_o;
    logic         lu_hit_o;
    logic [127:0] port_content_q_o;
    logic [123:0] port_tags_q_o;

    cva6_tlb_sv32 #(.TLB_ENTRIES(4), .ASID_WIDTH(1)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .update_i              (update_i),
        .lu_access_i           (lu_access_i),
        .lu_asid_i             (lu_asid_i),
        .lu_vaddr_i            (lu_vaddr_i),
        .lu_content_o          (lu_content_o),
        .asid_to_be_flushed_i  (asid_to_be_flushed_i),
        .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
        .lu_is_4M_o            (lu_is_4M_o),
        .lu_hit_o              (lu_hit_o),
        .port_content_q_o      (port_content_q_o),
        .port_tags_q_o         (port_tags_q_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    logic chk_req = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_HIT:   return {31'b0, lu_hit_o};
            K_CONT:  return lu_content_o;
            K_4M:    return {31'b0, lu_is_4M_o};
            K_TAG:   return {1'b0, port_tags_q_o[idx*31 +: 31]};
            K_ECONT: return port_content_q_o[idx*32 +: 32];
            default: return {31'b0, port_tags_q_o[idx*31]};
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (chk_req) begin
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] a;
                e = q.pop_front();
                a = actual(e.kind, e.idx);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.exp);
                end
            end
        end
    end

    task automatic push(input int kind, input int idx, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        chk_req = 1'b1;
        @(posedge clk_i); #1;
        chk_req     = 1'b0;
        update_i    = '0;
        flush_i     = 1'b0;
        lu_access_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; flush_i = 1'b0; update_i = '0; lu_access_i = 1'b0;
        lu_asid_i = '0; lu_vaddr_i = '0; asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic do_update(input logic [31:0] va, input logic [8:0] asid, input logic is4m,
                             input logic [31:0] content);
        update_i = {1'b1, is4m, va[31:22], va[21:12], asid, content};
        step();
    endtask

    task automatic do_flush(input logic asid, input logic [31:0] va);
        flush_i = 1'b1; asid_to_be_flushed_i = asid; vaddr_to_be_flushed_i = va;
        step();
    endtask

    task automatic lookup(input logic [31:0] va, input logic asid, input logic acc, input logic hit,
                          input logic [31:0] content, input logic is4m, input string name);
        lu_vaddr_i = va; lu_asid_i = asid; lu_access_i = acc;
        push(K_HIT, 0, {31'b0, hit}, {name, "_hit"});
        push(K_CONT, 0, content, {name, "_content"});
        push(K_4M, 0, {31'b0, is4m}, {name, "_4m"});
        step();
    endtask

    initial begin
        do_reset();

        lookup(32'h1234_5000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "reset_lu");
        for (int i = 0; i < 4; i++) begin
            push(K_TAG, i, 32'h0, $sformatf("reset_tag%0d", i));
            push(K_ECONT, i, 32'h0, $sformatf("reset_content%0d", i));
        end
        step();

        // Basic fill; 0xDEADBEE1 has PTE bit 5 set, so the entry is global.
        do_update(32'h1234_5000, 9'd1, 1'b0, 32'hDEAD_BEE1);
        lookup(32'h1234_5000, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEE1, 1'b0, "basic_lu");
        push(K_TAG, 0, {1'b0, 9'd1, 10'h048, 10'h345, 1'b0, 1'b1}, "basic_tag0");
        step();
        lookup(32'h1234_5000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEE1, 1'b0, "global_asid0_lu");
        lookup(32'h1234_6000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "vpn0_miss_lu");

        do_update(32'h1200_0000, 9'd1, 1'b1, 32'h0000_0C01);
        lookup(32'h1200_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0C01, 1'b1, "4m_low_lu");
        lookup(32'h123F_F000, 1'b1, 1'b0, 1'b1, 32'h0000_0C01, 1'b1, "4m_high_lu");
        lookup(32'h1234_5000, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEE1, 1'b0, "lowest_index_lu");
        lookup(32'h1240_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "4m_vpn1_miss_lu");

        // Replacement: fill four, evict entry 0, then touch entry 1 so entry 2 goes next.
        do_reset();
        do_update(32'h1000_0000, 9'd1, 1'b0, 32'h0000_0100);
        do_update(32'h2000_0000, 9'd1, 1'b0, 32'h0000_0200);
        do_update(32'h3000_0000, 9'd1, 1'b0, 32'h0000_0300);
        do_update(32'h4000_0000, 9'd1, 1'b0, 32'h0000_0400);
        do_update(32'h5000_0000, 9'd1, 1'b0, 32'h0000_0500);
        push(K_ECONT, 0, 32'h0000_0500, "evict_e0_content");
        step();
        lookup(32'h1000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "evicted_lu");
        lookup(32'h2000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, "touch_e1_lu");
        do_update(32'h6000_0000, 9'd1, 1'b0, 32'h0000_0600);
        push(K_ECONT, 2, 32'h0000_0600, "evict_e2_content");
        push(K_ECONT, 1, 32'h0000_0200, "keep_e1_content");
        push(K_ECONT, 3, 32'h0000_0400, "keep_e3_content");
        step();

        do_flush(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) push(K_VALID, i, 32'h0, $sformatf("flush_all_valid%0d", i));
        push(K_ECONT, 0, 32'h0000_0500, "flush_keep_content0");
        push(K_ECONT, 2, 32'h0000_0600, "flush_keep_content2");
        push(K_TAG, 1, {1'b0, 9'd1, 10'h080, 10'h000, 1'b0, 1'b0}, "flush_keep_tag1");
        step();
        lookup(32'h2000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "post_flush_lu");

        // ASID flush spares global entries; flush beats a same-cycle update.
        do_reset();
        do_update(32'h7000_0000, 9'd1, 1'b0, 32'h0000_0021);
        do_update(32'h8000_0000, 9'd1, 1'b0, 32'h0000_0001);
        do_flush(1'b1, 32'h0);
        lookup(32'h7000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0021, 1'b0, "global_survives_lu");
        lookup(32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "asid_flushed_lu");
        flush_i = 1'b1; asid_to_be_flushed_i = 1'b0; vaddr_to_be_flushed_i = 32'h9000_0000;
        update_i = {1'b1, 1'b0, 10'h240, 10'h000, 9'd1, 32'h0000_0901};
        step();
        push(K_TAG, 2, 32'h0, "flush_drops_update_tag");
        push(K_ECONT, 2, 32'h0, "flush_drops_update_content");
        push(K_VALID, 1, 32'h0, "flush_drops_update_e1");
        step();
        lookup(32'h9000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "dropped_update_lu");
        do_flush(1'b0, 32'h7000_0000);
        lookup(32'h7000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "vaddr_flush_lu");

        @(posedge clk_i); #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
